// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types for the instruction-fetch stage and the decode/control unit:
//   pc_src_t      - PC-source select that decode hands back to fetch
//   fetch_state_t - fetch sequencer states (exposed on dbg_state)
//   opcode_t      - primary opcodes the control unit decodes (HALT included)
//   funct_t       - R-type function codes
// Helper: pc_plus4() gives the sequential successor of a PC. Arithmetic is
// modulo 2^32, so the PC wraps silently.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int unsigned INSTR_W = 32;

   typedef enum logic [1:0] {
      PC_NEXT   = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_JR     = 2'b11
   } pc_src_t;

   typedef enum logic [1:0] {
      FETCH      = 2'b00,
      REDIR_WAIT = 2'b01,
      HALTED     = 2'b10
   } fetch_state_t;

   typedef enum logic [5:0] {
      RTYPE = 6'h00,
      J     = 6'h02,
      JAL   = 6'h03,
      BEQ   = 6'h04,
      BNE   = 6'h05,
      ADDI  = 6'h08,
      LW    = 6'h23,
      SW    = 6'h2B,
      HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      SLL  = 6'h00,
      JR   = 6'h08,
      ADD  = 6'h20,
      SUB  = 6'h22,
      AND_ = 6'h24,
      OR_  = 6'h25
   } funct_t;

   function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc_in);
      return pc_in + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Groups every non-clock signal of the fetch stage.
//   imem side   : ihit, iload (to fetch); imemREN, imemaddr (from fetch)
//   decode side : stall, flush, halt, rd_en, pc_src, br_taken, ext_imm,
//                 jaddr, rs_val (to fetch); ifid_*, opcode, funct (from fetch)
//   observation : pc, fetch_cnt, bubble_cnt, dbg_state (from fetch)
// Modports: master = the fetch stage, slave = imem + decode environment.
// imem handshake: the fetch stage holds imemaddr stable while imemREN=1;
// iload is consumed only in a cycle where ihit=1 for that address, and a
// cycle without ihit simply means "try again next cycle".
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic               ihit;
   logic [31:0]        iload;
   logic               imemREN;
   logic [31:0]        imemaddr;

   logic               stall;
   logic               flush;
   logic               halt;
   logic               rd_en;
   logic [1:0]         pc_src;
   logic               br_taken;
   logic [31:0]        ext_imm;
   logic [25:0]        jaddr;
   logic [31:0]        rs_val;

   logic [31:0]        ifid_instr;
   logic [31:0]        ifid_npc;
   logic               ifid_valid;
   logic [5:0]         opcode;
   logic [5:0]         funct;

   logic [31:0]        pc;
   logic [31:0]        fetch_cnt;
   logic [31:0]        bubble_cnt;
   fetch_state_t       dbg_state;

   modport master (
      input  ihit, iload, stall, flush, halt, rd_en, pc_src, br_taken,
             ext_imm, jaddr, rs_val,
      output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, opcode,
             funct, pc, fetch_cnt, bubble_cnt, dbg_state
   );

   modport slave (
      output ihit, iload, stall, flush, halt, rd_en, pc_src, br_taken,
             ext_imm, jaddr, rs_val,
      input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, opcode,
             funct, pc, fetch_cnt, bubble_cnt, dbg_state
   );

endinterface

// File: rtl/fetch_stage_pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Combinational redirect-target mux, all relative to the decode
// instruction's PC+4 (ifid_npc):
//   PC_BRANCH : ifid_npc + (ext_imm << 2)
//   PC_JUMP   : {ifid_npc[31:28], jaddr, 2'b00}
//   PC_JR     : rs_val
//   PC_NEXT   : ifid_npc (unused by the caller, kept defined)
// Ports: ifid_npc, ext_imm, jaddr, rs_val, pc_src in; target out.
// -----------------------------------------------------------------------------
module pc_target_calc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] ifid_npc,
   input  logic [31:0] ext_imm,
   input  logic [25:0] jaddr,
   input  logic [31:0] rs_val,
   input  logic [1:0]  pc_src,
   output logic [31:0] target
);

   always_comb begin
      target = ifid_npc;
      case (pc_src_t'(pc_src))
         PC_BRANCH: target = ifid_npc + {ext_imm[29:0], 2'b00};
         PC_JUMP:   target = {ifid_npc[31:28], jaddr, 2'b00};
         PC_JR:     target = rs_val;
         default:   target = ifid_npc;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch plus IF/ID pipeline register. Owns the PC, reads imem,
// latches {instr, PC+4, valid}, and takes redirects/halt from decode.
// Ports: CLK, nRST (async, active low), bus (fetch_stage_if.master).
// Parameters: PC_INIT (reset PC), WORD_W (32 only).
// Optional build macro IFETCH_PERF_EN: enables the saturating fetch_cnt /
// bubble_cnt performance counters; without it both read as 0.
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int unsigned WORD_W  = 32
)(
   input  logic           CLK,
   input  logic           nRST,
   fetch_stage_if.master  bus
);

   localparam logic [WORD_W-1:0] ZERO_W = '0;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic [31:0]  ifid_npc_q, ifid_npc_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic         hold;        // stall freezes PC and IF/ID this cycle
   logic         load_valid;  // IF/ID captures a real fetched word
   logic         redir;
   logic [31:0]  target;

   pc_target_calc u_target (
      .ifid_npc (ifid_npc_q),
      .ext_imm  (bus.ext_imm),
      .jaddr    (bus.jaddr),
      .rs_val   (bus.rs_val),
      .pc_src   (bus.pc_src),
      .target   (target)
   );

   // Only a valid decode instruction may steer the PC; an untaken branch
   // falls through to sequential fetch.
   assign redir = bus.rd_en & ifid_valid_q &
                  (((bus.pc_src == PC_BRANCH) & bus.br_taken) | bus.pc_src[1]);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      ifid_instr_d = ZERO_W;
      ifid_npc_d   = ZERO_W;
      ifid_valid_d = 1'b0;
      hold         = 1'b0;
      load_valid   = 1'b0;
      case (state_q)
         FETCH: begin
            if (bus.halt) begin
               state_d = HALTED;
            end else if (bus.stall) begin
               // decode will present its redirect again once the stall clears
               hold         = 1'b1;
               ifid_instr_d = ifid_instr_q;
               ifid_npc_d   = ifid_npc_q;
               ifid_valid_d = ifid_valid_q;
            end else if (redir) begin
               if (bus.ihit) begin
                  pc_d = target;
               end else begin
                  // imemaddr must stay put until the outstanding read returns
                  pend_pc_d = target;
                  state_d   = REDIR_WAIT;
               end
            end else if (bus.flush) begin
               if (bus.ihit) pc_d = pc_plus4(pc_q);
            end else if (bus.ihit) begin
               load_valid   = 1'b1;
               ifid_instr_d = bus.iload;
               ifid_npc_d   = pc_plus4(pc_q);
               ifid_valid_d = 1'b1;
               pc_d         = pc_plus4(pc_q);
            end
         end
         REDIR_WAIT: begin
            if (bus.halt) begin
               state_d = HALTED;
            end else if (bus.ihit) begin
               // the returned word is wrong-path; drop it and jump
               pc_d    = pend_pc_q;
               state_d = FETCH;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= FETCH;
         pc_q         <= PC_INIT;
         pend_pc_q    <= '0;
         ifid_instr_q <= '0;
         ifid_npc_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_npc_q   <= ifid_npc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (load_valid && (fetch_cnt_q != 32'hFFFF_FFFF))
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((state_q != HALTED) && (!ifid_valid_d || hold) &&
          (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.fetch_cnt  = fetch_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;
`else
   logic unused_perf;
   assign unused_perf    = hold ^ load_valid;
   assign bus.fetch_cnt  = '0;
   assign bus.bubble_cnt = '0;
`endif

   assign bus.imemREN    = (state_q != HALTED);
   assign bus.imemaddr   = pc_q;
   assign bus.pc         = pc_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.ifid_npc   = ifid_npc_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.opcode     = ifid_instr_q[31:26];
   assign bus.funct      = ifid_instr_q[5:0];
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Table of per-cycle {stimulus, expected IF/ID + PC + state} records for
// fetch_stage, driven through fetch_stage_if, plus hand-written sequences
// for asynchronous reset, PC wrap and redirect-wait-then-halt.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   typedef struct packed {
      logic        ihit;
      logic [31:0] iload;
      logic        stall;
      logic        flush;
      logic        halt;
      logic        rd_en;
      logic [1:0]  pc_src;
      logic        br_taken;
      logic [31:0] ext_imm;
      logic [25:0] jaddr;
      logic [31:0] rs_val;
   } stim_t;

   typedef struct packed {
      logic [31:0]  pc;
      logic [31:0]  instr;
      logic [31:0]  npc;
      logic         valid;
      logic         ren;
      fetch_state_t state;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   logic CLK;
   logic nRST;
   fetch_stage_if bus ();

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];
   fetch_state_t prev_state;
   logic [31:0] exp_fetch_cnt;
   logic [31:0] exp_bubble_cnt;

   fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, need finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic stim_t st(input logic ihit, input logic [31:0] iload,
                                input logic stall, input logic flush,
                                input logic halt, input logic rd_en,
                                input logic [1:0] pc_src, input logic br,
                                input logic [31:0] ext, input logic [25:0] ja,
                                input logic [31:0] rs);
      stim_t r;
      r.ihit = ihit; r.iload = iload; r.stall = stall; r.flush = flush;
      r.halt = halt; r.rd_en = rd_en; r.pc_src = pc_src; r.br_taken = br;
      r.ext_imm = ext; r.jaddr = ja; r.rs_val = rs;
      return r;
   endfunction

   function automatic exp_t ex(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] npc, input logic valid,
                               input logic ren, input fetch_state_t state);
      exp_t r;
      r.pc = pc; r.instr = instr; r.npc = npc; r.valid = valid;
      r.ren = ren; r.state = state;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, need %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.ihit = 0; bus.iload = 0; bus.stall = 0; bus.flush = 0; bus.halt = 0;
      bus.rd_en = 0; bus.pc_src = 0; bus.br_taken = 0; bus.ext_imm = 0;
      bus.jaddr = 0; bus.rs_val = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"},       bus.pc, 32'h0);
      check({tag, "_imemaddr"}, bus.imemaddr, 32'h0);
      check({tag, "_imemREN"},  {31'd0, bus.imemREN}, 32'd1);
      check({tag, "_instr"},    bus.ifid_instr, 32'h0);
      check({tag, "_npc"},      bus.ifid_npc, 32'h0);
      check({tag, "_valid"},    {31'd0, bus.ifid_valid}, 32'd0);
      check({tag, "_state"},    {30'd0, bus.dbg_state}, {30'd0, FETCH});
      check({tag, "_fetch_cnt"},  bus.fetch_cnt, 32'd0);
      check({tag, "_bubble_cnt"}, bus.bubble_cnt, 32'd0);
      prev_state = FETCH;
      exp_fetch_cnt = 0;
      exp_bubble_cnt = 0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic score(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s_queue: got empty queue, need one entry", tag);
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_pc"},       bus.pc, e.pc);
      check({tag, "_imemaddr"}, bus.imemaddr, e.pc);
      check({tag, "_imemREN"},  {31'd0, bus.imemREN}, {31'd0, e.ren});
      check({tag, "_instr"},    bus.ifid_instr, e.instr);
      check({tag, "_npc"},      bus.ifid_npc, e.npc);
      check({tag, "_valid"},    {31'd0, bus.ifid_valid}, {31'd0, e.valid});
      check({tag, "_opcode"},   {26'd0, bus.opcode}, {26'd0, e.instr[31:26]});
      check({tag, "_funct"},    {26'd0, bus.funct}, {26'd0, e.instr[5:0]});
      check({tag, "_state"},    {30'd0, bus.dbg_state}, {30'd0, e.state});
      check({tag, "_fetch_cnt"},  bus.fetch_cnt, exp_fetch_cnt);
      check({tag, "_bubble_cnt"}, bus.bubble_cnt, exp_bubble_cnt);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input string tag, input stim_t s, input exp_t e);
      logic stall_hold;
      @(negedge CLK);
      bus.ihit = s.ihit; bus.iload = s.iload; bus.stall = s.stall;
      bus.flush = s.flush; bus.halt = s.halt; bus.rd_en = s.rd_en;
      bus.pc_src = s.pc_src; bus.br_taken = s.br_taken;
      bus.ext_imm = s.ext_imm; bus.jaddr = s.jaddr; bus.rs_val = s.rs_val;
      exp_q.push_back(e);
`ifdef IFETCH_PERF_EN
      stall_hold = (prev_state == FETCH) && s.stall && !s.halt;
      if (e.valid && !stall_hold && exp_fetch_cnt != 32'hFFFF_FFFF)
         exp_fetch_cnt++;
      if (prev_state != HALTED && (!e.valid || stall_hold) &&
          exp_bubble_cnt != 32'hFFFF_FFFF)
         exp_bubble_cnt++;
`else
      stall_hold = 1'b0;
`endif
      prev_state = e.state;
      @(posedge CLK);
      #1;
      score(tag);
      if (stall_hold) clear_inputs();
   endtask

   // ---------------- test ----------------
   vec_t vecs[24];

   initial begin
      localparam logic [31:0] A = 32'h8C22_0004, B = 32'h0043_2020,
                              C = 32'h1000_0003, D = 32'h1022_FFFE,
                              E = 32'h2108_0001, F = 32'h0000_000D,
                              G = 32'h0800_0040, H = 32'hDEAD_BEEF,
                              I = 32'h03E0_0008, K = 32'h2002_0005,
                              L = 32'hFC00_0000, M = 32'hFFFF_FFFF;
      localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

      // three sequential fetches
      vecs[0]  = '{st(1, A, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h4,  A, 32'h4,  1,1,FETCH)};
      vecs[1]  = '{st(1, B, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h8,  B, 32'h8,  1,1,FETCH)};
      vecs[2]  = '{st(1, C, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'hC,  C, 32'hC,  1,1,FETCH)};
      // imem misses: bubbles, PC holds
      vecs[3]  = '{st(0, M, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'hC,  0, 0, 0,1,FETCH)};
      vecs[4]  = '{st(0, M, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'hC,  0, 0, 0,1,FETCH)};
      // taken backward branch with ihit
      vecs[5]  = '{st(1, D, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h10, D, 32'h10, 1,1,FETCH)};
      vecs[6]  = '{st(1, M, 0,0,0,1, 2'b01,1, NEG2, 0, 0), ex(32'h8, 0, 0, 0,1,FETCH)};
      // branch not taken falls through
      vecs[7]  = '{st(1, E, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'hC,  E, 32'hC,  1,1,FETCH)};
      vecs[8]  = '{st(1, F, 0,0,0,1, 2'b01,0, NEG2, 0, 0), ex(32'h10, F, 32'h10, 1,1,FETCH)};
      // JR with ihit to 0x1000_0000, then fetch the jump
      vecs[9]  = '{st(1, M, 0,0,0,1, 2'b11,0, 0, 0, 32'h1000_0000), ex(32'h1000_0000, 0, 0, 0,1,FETCH)};
      vecs[10] = '{st(1, G, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h1000_0004, G, 32'h1000_0004, 1,1,FETCH)};
      // jump without ihit: wait with old address held, discard returned word
      vecs[11] = '{st(0, M, 0,0,0,1, 2'b10,0, 0, 26'h40, 0), ex(32'h1000_0004, 0, 0, 0,1,REDIR_WAIT)};
      vecs[12] = '{st(0, M, 1,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h1000_0004, 0, 0, 0,1,REDIR_WAIT)};
      vecs[13] = '{st(1, H, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h1000_0100, 0, 0, 0,1,FETCH)};
      // stall blocks ihit and JR; JR taken once the stall drops
      vecs[14] = '{st(1, I, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h1000_0104, I, 32'h1000_0104, 1,1,FETCH)};
      vecs[15] = '{st(1, M, 1,0,0,1, 2'b11,0, 0, 0, 32'h200), ex(32'h1000_0104, I, 32'h1000_0104, 1,1,FETCH)};
      vecs[16] = '{st(1, M, 0,0,0,1, 2'b11,0, 0, 0, 32'h200), ex(32'h200, 0, 0, 0,1,FETCH)};
      // flush with and without ihit
      vecs[17] = '{st(1, K, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h204, K, 32'h204, 1,1,FETCH)};
      vecs[18] = '{st(1, M, 0,1,0,0, 2'b00,0, 0, 0, 0), ex(32'h208, 0, 0, 0,1,FETCH)};
      vecs[19] = '{st(0, M, 0,1,0,0, 2'b00,0, 0, 0, 0), ex(32'h208, 0, 0, 0,1,FETCH)};
      // halt beats stall; afterwards ihit/flush/redirect ignored
      vecs[20] = '{st(1, L, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h20C, L, 32'h20C, 1,1,FETCH)};
      vecs[21] = '{st(1, M, 1,0,1,1, 2'b11,0, 0, 0, 32'h400), ex(32'h20C, 0, 0, 0,0,HALTED)};
      vecs[22] = '{st(1, M, 0,1,0,1, 2'b10,0, 0, 26'h3, 0), ex(32'h20C, 0, 0, 0,0,HALTED)};
      vecs[23] = '{st(1, M, 1,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h20C, 0, 0, 0,0,HALTED)};

      clear_inputs();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      check_reset_state("reset");
      nRST = 1'b1;

      for (int i = 0; i < 24; i++) begin
         drive($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
      end

      // asynchronous reset pulse mid-cycle while halted
      @(negedge CLK);
      clear_inputs();
      #2 nRST = 1'b0;
      #1 check_reset_state("async_reset");
      @(negedge CLK);
      nRST = 1'b1;

      // PC wrap through JR to the last word
      drive("wrap0", st(1, A, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h4, A, 32'h4, 1,1,FETCH));
      drive("wrap1", st(1, M, 0,0,0,1, 2'b11,0, 0, 0, 32'hFFFF_FFFC), ex(32'hFFFF_FFFC, 0, 0, 0,1,FETCH));
      drive("wrap2", st(1, B, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h0, B, 32'h0, 1,1,FETCH));
      // pending branch abandoned by halt: PC stays at the old address
      drive("wait_halt0", st(0, M, 0,0,0,1, 2'b01,1, 32'h1, 0, 0), ex(32'h0, 0, 0, 0,1,REDIR_WAIT));
      drive("wait_halt1", st(1, M, 0,0,1,0, 2'b00,0, 0, 0, 0), ex(32'h0, 0, 0, 0,0,HALTED));
      drive("wait_halt2", st(1, C, 0,0,0,0, 2'b00,0, 0, 0, 0), ex(32'h0, 0, 0, 0,0,HALTED));

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries left, need 0", exp_q.size());
      end
      checks++;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
